// File: rtl/alu_share_arb.sv
// alu_share_arb: sequences two requesters onto one shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins) instead of round-robin.
module alu_share_arb #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_eq,
    output logic            rsp_less,
    output logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_eq,
    input  logic            alu_less,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic            owner;
    logic [OP_W-1:0] op_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] res_q;
    logic            eq_q;
    logic            less_q;

    logic pick1;
    logic grant0;
    logic grant1;
    logic accept;
    logic rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb pick1 = !req0_valid;
`else
    logic last_grant;

    // Under contention the port that lost last time goes first.
    always_comb pick1 = req1_valid && (!req0_valid || !last_grant);
`endif

    // Readies stay low through reset so nothing is accepted and then lost.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            grant0 = req0_valid && !pick1;
            grant1 = req1_valid && pick1;
        end
    end

    assign accept   = grant0 || grant1;
    assign rsp_done = (state == RESP) &&
                      (owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_op     = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        busy       = (state != IDLE);
        unique case (state)
            EXEC: begin
                alu_op  = op_q;
                alu_op1 = op1_q;
                alu_op2 = op2_q;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= 1'b0;
            op_q  <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            unique case (1'b1)
                grant0: begin
                    owner <= 1'b0;
                    op_q  <= req0_op;
                    op1_q <= req0_op1;
                    op2_q <= req0_op2;
                end
                grant1: begin
                    owner <= 1'b1;
                    op_q  <= req1_op;
                    op1_q <= req1_op1;
                    op2_q <= req1_op2;
                end
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`endif

    // Result is only sampled while the ALU sees our operands, then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            eq_q   <= 1'b0;
            less_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q  <= alu_result;
            eq_q   <= alu_eq;
            less_q <= alu_less;
        end
    end

    assign rsp_result = res_q;
    assign rsp_eq     = eq_q;
    assign rsp_less   = less_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and randomized checks of the shared-ALU arbiter.
// The bench models the ALU; define ALU_ARB_FIXED_PRIO_EN to check that build.
`timescale 1ns/1ps
module tb_alu_share_arb;
    localparam int XLEN = 64;
    localparam int OP_W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0_valid = 1'b0;
    logic            req0_ready;
    logic [OP_W-1:0] req0_op = '0;
    logic [XLEN-1:0] req0_op1 = '0;
    logic [XLEN-1:0] req0_op2 = '0;
    logic            req1_valid = 1'b0;
    logic            req1_ready;
    logic [OP_W-1:0] req1_op = '0;
    logic [XLEN-1:0] req1_op1 = '0;
    logic [XLEN-1:0] req1_op2 = '0;
    logic            rsp0_valid;
    logic            rsp0_ready = 1'b0;
    logic            rsp1_valid;
    logic            rsp1_ready = 1'b0;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_eq;
    logic            rsp_less;
    logic [OP_W-1:0] alu_op;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [XLEN-1:0] alu_result;
    logic            alu_eq;
    logic            alu_less;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          port;
        logic [63:0] res;
        int          at;
    } exp_t;

    logic [3:0] op_tab [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101,
                               4'b0111, 4'b1000, 4'b1001, 4'b1100};

    alu_share_arb #(.XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_eq(rsp_eq), .rsp_less(rsp_less),
        .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_eq(alu_eq), .alu_less(alu_less),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_alu(input logic [3:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return a ^ b;
            4'b0101: return a | b;
            4'b0111: return a & b;
            4'b1000: return a << b[5:0];
            4'b1001: return a >> b[5:0];
            4'b1100: return {63'b0, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] ref_flags(input logic [63:0] a,
                                             input logic [63:0] b);
        return {a == b, $signed(a) < $signed(b)};
    endfunction

    assign alu_result = ref_alu(alu_op, alu_op1, alu_op2);
    assign {alu_eq, alu_less} = ref_flags(alu_op1, alu_op2);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_req(input bit p);
        logic [3:0]  o;
        logic [63:0] a;
        logic [63:0] b;
        o = op_tab[$urandom_range(0, 7)];
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
        if (p) begin
            req1_valid = 1'b1; req1_op = o; req1_op1 = a; req1_op2 = b;
        end else begin
            req0_valid = 1'b1; req0_op = o; req0_op1 = a; req0_op2 = b;
        end
    endtask

    task automatic wait_grant(input bit p, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            mid_cycle();
            if ((p ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mid_cycle();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        if (ok) next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        mid_cycle();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hs: got %b want 0000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        n_tests++;
        if ({rsp_result, rsp_eq, rsp_less} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h/%b/%b want 0/0/0",
                     rsp_result, rsp_eq, rsp_less);
        end
        n_tests++;
        if ({alu_op, alu_op1, alu_op2} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: got %h %h %h want 0", alu_op, alu_op1, alu_op2);
        end
        next_cycle();
    endtask

    task automatic test_port0_add();
        int a;
        int seen1 = 0;
        do_reset();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 64'd5; req0_op2 = 64'd7;
        mid_cycle();
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL p0_accept: got %b want 1", req0_ready);
        end
        a = cyc;
        if (rsp1_valid !== 1'b0) seen1++;
        next_cycle();
        req0_valid = 1'b0;
        mid_cycle();
        if (rsp1_valid !== 1'b0) seen1++;
        n_tests++;
        if ({rsp0_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL p0_exec: got %b want 01", {rsp0_valid, busy});
        end
        next_cycle();
        mid_cycle();
        if (rsp1_valid !== 1'b0) seen1++;
        n_tests++;
        if (rsp0_valid !== 1'b1 || cyc - a != 2) begin
            n_fail++;
            $display("FAIL p0_latency: got valid %b at +%0d want 1 at +2",
                     rsp0_valid, cyc - a);
        end
        n_tests++;
        if (rsp_result !== 64'd12) begin
            n_fail++; $display("FAIL p0_result: got %h want c", rsp_result);
        end
        next_cycle();
        mid_cycle();
        if (rsp1_valid !== 1'b0) seen1++;
        n_tests++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL p0_release: got %b want 00", {rsp0_valid, busy});
        end
        n_tests++;
        if (seen1 != 0) begin
            n_fail++; $display("FAIL p0_rsp1_quiet: got %0d rsp1 cycles want 0", seen1);
        end
        rsp0_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_both_from_reset();
        bit got;
        bit ok;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'b0001; req0_op1 = 64'd10; req0_op2 = 64'd3;
        req1_valid = 1'b1; req1_op = 4'b0111; req1_op1 = 64'hF0; req1_op2 = 64'h3C;
        mid_cycle();
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL both_first: got %b want 10", {req0_ready, req1_ready});
        end
        next_cycle();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        next_cycle();
        mid_cycle();
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp_result !== 64'd7) begin
            n_fail++;
            $display("FAIL both_p0_rsp: got %b/%h want 1/7", rsp0_valid, rsp_result);
        end
        next_cycle();
        mid_cycle();
        n_tests++;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL both_second: got %b want 10", {req0_ready, req1_ready});
        end
        next_cycle();
        req0_valid = 1'b0;
        wait_grant(1'b1, 8, got);
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL both_p1_grant: got none want grant");
        end
        next_cycle();
        req1_valid = 1'b0;
`else
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL both_second: got %b want 01", {req0_ready, req1_ready});
        end
        next_cycle();
        req1_valid = 1'b0;
`endif
        next_cycle();
        mid_cycle();
        n_tests++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 64'h30) begin
            n_fail++;
            $display("FAIL both_p1_rsp: got %b%b/%h want 10/30",
                     rsp1_valid, rsp0_valid, rsp_result);
        end
        next_cycle();
`ifndef ALU_ARB_FIXED_PRIO_EN
        mid_cycle();
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL both_p0_again: got %b want 1", req0_ready);
        end
        next_cycle();
`endif
        req0_valid = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL both_idle: got busy want idle");
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit got;
        req1_valid = 1'b1; req1_op = 4'b1100; req1_op1 = 64'd3; req1_op2 = 64'd9;
        wait_grant(1'b1, 4, got);
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL bp_grant: got none want grant");
        end
        next_cycle();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 64'd1; req0_op2 = 64'd1;
        mid_cycle();
        n_tests++;
        if (req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_exec_nogrant: got %b want 0", req0_ready);
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            mid_cycle();
            n_tests++;
            if ({rsp1_valid, rsp0_valid, rsp_less, rsp_eq, busy, req0_ready} !== 6'b101010) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %b want 101010", i,
                         {rsp1_valid, rsp0_valid, rsp_less, rsp_eq, busy, req0_ready});
            end
            n_tests++;
            if (rsp_result !== 64'd1) begin
                n_fail++; $display("FAIL bp_result%0d: got %h want 1", i, rsp_result);
            end
            next_cycle();
        end
        rsp1_ready = 1'b1;
        mid_cycle();
        n_tests++;
        if ({rsp1_valid, req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_handshake: got %b want 10", {rsp1_valid, req0_ready});
        end
        next_cycle();
        rsp1_ready = 1'b0;
        mid_cycle();
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_p0_after: got %b want 1", req0_ready);
        end
        next_cycle();
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        next_cycle();
        mid_cycle();
        n_tests++;
        if ({rsp0_valid, rsp_eq} !== 2'b11 || rsp_result !== 64'd2) begin
            n_fail++;
            $display("FAIL bp_p0_rsp: got %b%b/%h want 11/2",
                     rsp0_valid, rsp_eq, rsp_result);
        end
        next_cycle();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_contention();
        exp_t e;
        exp_t sb [$];
        int   gp [$];
        int   gc [$];
        int   ng = 0;
        int   nrsp = 0;
        int   want;
        bit   g0;
        bit   g1;
        bit   ok;
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(1'b0);
        set_req(1'b1);
        for (int i = 0; i < 40; i++) begin
            mid_cycle();
            g0 = (req0_ready === 1'b1);
            g1 = (req1_ready === 1'b1);
            if (g0 || g1) begin
                e.port = g1 ? 1 : 0;
                e.at   = cyc + 2;
                e.res  = g1 ? ref_alu(req1_op, req1_op1, req1_op2)
                            : ref_alu(req0_op, req0_op1, req0_op2);
                sb.push_back(e);
                gp.push_back(e.port);
                gc.push_back(cyc);
                ng++;
            end
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                nrsp++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL cont_rsp: got response want none pending");
                end else begin
                    e = sb.pop_front();
                    if ({rsp0_valid, rsp1_valid} !== (e.port == 1 ? 2'b01 : 2'b10) ||
                        cyc != e.at || rsp_result !== e.res) begin
                        n_fail++;
                        $display("FAIL cont_rsp%0d: got v%b c%0d %h want p%0d c%0d %h",
                                 nrsp, {rsp0_valid, rsp1_valid}, cyc, rsp_result,
                                 e.port, e.at, e.res);
                    end
                end
            end
            next_cycle();
            if (ng >= 6) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else begin
                if (g0) set_req(1'b0);
                if (g1) set_req(1'b1);
            end
            if (nrsp >= 6) break;
        end
        n_tests++;
        if (nrsp != 6 || gp.size() != 6) begin
            n_fail++;
            $display("FAIL cont_count: got %0d rsp %0d grants want 6/6", nrsp, gp.size());
        end
        for (int k = 0; k < gp.size(); k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            want = 0;
`else
            want = k % 2;
`endif
            n_tests++;
            if (gp[k] != want || (k > 0 && gc[k] - gc[k-1] != 3)) begin
                n_fail++;
                $display("FAIL cont_grant%0d: got p%0d gap %0d want p%0d gap 3",
                         k, gp[k], k > 0 ? gc[k] - gc[k-1] : 3, want);
            end
        end
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL cont_idle: got busy want idle");
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        bit got;
        bit ok;
        int seen = 0;
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 64'd5; req0_op2 = 64'd7;
        wait_grant(1'b0, 4, got);
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL rx_grant: got none want grant");
        end
        next_cycle();
        req0_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mid_cycle();
        n_tests++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b000 ||
            {rsp_result, rsp_eq, rsp_less} !== 66'd0 ||
            {alu_op, alu_op1, alu_op2} !== '0) begin
            n_fail++;
            $display("FAIL rx_outputs: got b%b v%b r%h a%h want all 0",
                     busy, rsp0_valid, rsp_result, alu_op1);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mid_cycle();
            if (rsp0_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rx_no_rsp: got %0d rsp cycles want 0", seen);
        end
        next_cycle();
        req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 64'd20; req0_op2 = 64'd22;
        req1_valid = 1'b1; req1_op = 4'b0001; req1_op1 = 64'd9;  req1_op2 = 64'd4;
        mid_cycle();
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rx_regrant: got %b want 10", {req0_ready, req1_ready});
        end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
        mid_cycle();
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp_result !== 64'd42) begin
            n_fail++;
            $display("FAIL rx_rsp: got %b/%h want 1/2a", rsp0_valid, rsp_result);
        end
        next_cycle();
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rx_idle: got busy want idle");
        end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_shift();
        bit got;
        bit ok;
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_op = 4'b1000; req1_op1 = 64'd1; req1_op2 = 64'd63;
        wait_grant(1'b1, 4, got);
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL sh_grant: got none want grant");
        end
        next_cycle();
        req1_valid = 1'b0;
        mid_cycle();
        n_tests++;
        if (alu_op !== 4'b1000 || alu_op1 !== 64'd1 || alu_op2 !== 64'd63) begin
            n_fail++;
            $display("FAIL sh_alu: got %h %h %h want 8 1 3f", alu_op, alu_op1, alu_op2);
        end
        next_cycle();
        mid_cycle();
        n_tests++;
        if (rsp1_valid !== 1'b1 || rsp_result !== 64'h8000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL sh_rsp: got %b/%h want 1/8000000000000000",
                     rsp1_valid, rsp_result);
        end
        n_tests++;
        if ({alu_op, alu_op2} !== '0) begin
            n_fail++; $display("FAIL sh_quiet: got %h %h want 0 0", alu_op, alu_op2);
        end
        next_cycle();
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL sh_idle: got busy want idle");
        end
        rsp1_ready = 1'b0;
    endtask

    // Reference: at most one op outstanding, response due two cycles after accept.
    task automatic test_random();
        bit          out = 1'b0;
        bit          own = 1'b0;
        bit          mlast = 1'b1;
        int          acc = 0;
        bit          held0 = 1'b0;
        bit          held1 = 1'b0;
        bit          ok;
        logic [1:0]  eg;
        logic [1:0]  ev;
        logic [63:0] eres = '0;
        logic [1:0]  eflg = '0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!held0) begin
                if ($urandom_range(0, 1) == 1) set_req(1'b0);
                else req0_valid = 1'b0;
            end
            if (!held1) begin
                if ($urandom_range(0, 1) == 1) set_req(1'b1);
                else req1_valid = 1'b0;
            end
            held0 = req0_valid;
            held1 = req1_valid;
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            mid_cycle();
            eg = 2'b00;
            if (!out) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    eg = 2'b10;
`else
                    eg = mlast ? 2'b10 : 2'b01;
`endif
                end else if (req0_valid) begin
                    eg = 2'b10;
                end else if (req1_valid) begin
                    eg = 2'b01;
                end
            end
            ev = (out && cyc >= acc + 2) ? (own ? 2'b01 : 2'b10) : 2'b00;
            n_tests++;
            if ({req0_ready, req1_ready} !== eg) begin
                n_fail++;
                $display("FAIL rand_grant@%0d: got %b want %b", cyc,
                         {req0_ready, req1_ready}, eg);
            end
            n_tests++;
            if ({rsp0_valid, rsp1_valid} !== ev || busy !== out) begin
                n_fail++;
                $display("FAIL rand_rsp@%0d: got %b busy %b want %b busy %b", cyc,
                         {rsp0_valid, rsp1_valid}, busy, ev, out);
            end
            if (ev != 2'b00) begin
                n_tests++;
                if ({rsp_result, rsp_eq, rsp_less} !== {eres, eflg}) begin
                    n_fail++;
                    $display("FAIL rand_data@%0d: got %h/%b%b want %h/%b", cyc,
                             rsp_result, rsp_eq, rsp_less, eres, eflg);
                end
                if (own ? rsp1_ready : rsp0_ready) out = 1'b0;
            end else if (eg != 2'b00) begin
                out   = 1'b1;
                own   = eg[0];
                mlast = eg[0];
                acc   = cyc;
                if (own) begin
                    eres  = ref_alu(req1_op, req1_op1, req1_op2);
                    eflg  = ref_flags(req1_op1, req1_op2);
                    held1 = 1'b0;
                end else begin
                    eres  = ref_alu(req0_op, req0_op1, req0_op2);
                    eflg  = ref_flags(req0_op1, req0_op2);
                    held0 = 1'b0;
                end
            end
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        wait_idle(ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rand_idle: got busy want idle");
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_port0_add();
        test_both_from_reset();
        test_backpressure();
        test_contention();
        test_reset_exec();
        test_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
